// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared widths, Q15 constants, framing defaults and Hamming coefficient generator
package mfcc_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int COEF_W        = 16;
    localparam int Q15_FRAC      = 15;
    localparam int Q15_MAX       = 32767;
    localparam int Q15_HALF      = 16384;
    localparam int FRAME_LEN_DEF = 256;
    localparam int HOP_LEN_DEF   = 128;

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        STREAM
    } frame_state_e;

    // Elaboration-time cosine; argument is folded into [-pi, pi] so the series converges quickly
    function automatic real cos_approx(input real x);
        real pi_v;
        real xr;
        real term;
        real sum;
        pi_v = 3.14159265358979323846;
        xr   = (x > pi_v) ? x - 2.0 * pi_v : x;
        term = 1.0;
        sum  = 1.0;
        for (int k = 1; k < 40; k++) begin
            term = -term * xr * xr / ((2.0 * k - 1.0) * (2.0 * k));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Unsigned Q15 Hamming coefficient for tap n of a len-point window
    function automatic logic [COEF_W-1:0] hamming_coef(input int n, input int len);
        real ang;
        real w;
        if (len < 2) return COEF_W'(Q15_MAX);
        ang = 2.0 * 3.14159265358979323846 * n / (len - 1);
        w   = 32767.0 * (0.54 - 0.46 * cos_approx(ang));
        return COEF_W'(int'(w));
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram: simple dual-port RAM, one write port and one registered read-first read port
module frame_buffer_ram
    import mfcc_pkg::*;
#(
    parameter int DEPTH = FRAME_LEN_DEF,
    parameter int WIDTH = SAMPLE_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // A read of the address being written returns the old contents
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (re) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/framing_window.sv
// framing_window: circular frame buffer emitting overlapping frames; Hamming window when FRAMING_HAMMING_EN is defined, rectangular otherwise
module framing_window
    import mfcc_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int HOP_LEN   = HOP_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] preemph_out,
    input  logic                       preemph_valid,
    output logic signed [SAMPLE_W-1:0] framed_out,
    output logic                       framed_valid,
    output logic                       frame_start,
    output logic                       frame_last,
    output logic                       overrun
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam int CW = AW + 1;

    frame_state_e state, state_nx;
    logic [AW-1:0] wr_ptr, rd_base, rd_idx, rd_addr;
    logic [CW-1:0] fill_cnt, hop_cnt;
    logic trig, streaming, rd_last, take;
    logic v1, s1, l1;
    logic signed [SAMPLE_W-1:0] rd_data, win;

    assign streaming = state == STREAM;
    assign rd_last   = streaming && rd_idx == AW'(FRAME_LEN - 1);
    assign trig      = preemph_valid && (fill_cnt == CW'(FRAME_LEN - 1) ||
                       (fill_cnt == CW'(FRAME_LEN) && hop_cnt == CW'(HOP_LEN - 1)));
    // A trigger on the final read cycle chains the next frame back-to-back
    assign take      = trig && (!streaming || rd_last);
    assign rd_addr   = rd_base + rd_idx;

    frame_buffer_ram #(.DEPTH(FRAME_LEN), .WIDTH(SAMPLE_W)) u_ram (
        .clk    (clk),
        .we     (preemph_valid && !rst),
        .wr_addr(wr_ptr),
        .wr_data(preemph_out),
        .re     (streaming),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    // Next state: any accepted trigger starts a frame, otherwise the last read returns to WAIT
    always_comb begin
        state_nx = take ? STREAM : (rd_last ? WAIT : state);
    end

    // State, write pointer, fill/hop counters, read sequencing and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            hop_cnt  <= '0;
            rd_base  <= '0;
            rd_idx   <= '0;
            overrun  <= 1'b0;
        end else begin
            state <= state_nx;
            if (preemph_valid) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fill_cnt <= (fill_cnt == CW'(FRAME_LEN)) ? fill_cnt : fill_cnt + CW'(1);
                hop_cnt  <= trig ? '0 : hop_cnt + CW'(1);
            end
            if (take) begin
                rd_base <= wr_ptr + AW'(1);
                rd_idx  <= '0;
            end else if (streaming) begin
                rd_idx <= rd_idx + AW'(1);
            end
            if (trig && !take) overrun <= 1'b1;
        end
    end

    // Stage 1 markers travel alongside the registered buffer read
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            v1 <= streaming;
            s1 <= streaming && rd_idx == '0;
            l1 <= rd_last;
        end
    end

`ifdef FRAMING_HAMMING_EN
    localparam int PW = SAMPLE_W + COEF_W + 1;

    logic [COEF_W-1:0] rom [FRAME_LEN];
    logic [COEF_W-1:0] coef_q;
    logic signed [PW-1:0] prod;

    for (genvar i = 0; i < FRAME_LEN; i++) begin : g_rom
        localparam logic [COEF_W-1:0] C = hamming_coef(i, FRAME_LEN);
        assign rom[i] = C;
    end

    // Coefficient fetched in step with the buffer read so both reach the multiplier together
    always_ff @(posedge clk) begin
        coef_q <= rom[rd_idx];
    end

    assign prod = PW'(rd_data) * PW'($signed({1'b0, coef_q}));
    assign win  = SAMPLE_W'((prod + PW'(Q15_HALF)) >>> Q15_FRAC);
`else
    assign win = rd_data;
`endif

    // Stage 2 output register; data is held at zero between frames
    always_ff @(posedge clk) begin
        if (rst) begin
            framed_out   <= '0;
            framed_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_last   <= 1'b0;
        end else begin
            framed_out   <= v1 ? win : '0;
            framed_valid <= v1;
            frame_start  <= s1;
            frame_last   <= l1;
        end
    end

endmodule
